// File: rtl/wrd_pkg.sv
// rtl/wrd_pkg.sv - word-width constants shared by the convolution and post-processing stages
// Contents: BW (activation width), MUL_OUT_BW (product width), ADD_OUT_BW (accumulator width).
package wrd_pkg;
    localparam int BW         = 8;
    localparam int MUL_OUT_BW = 16;
    localparam int ADD_OUT_BW = 18;
endpackage

// File: rtl/relu_quant.sv
// rtl/relu_quant.sv - combinational ReLU, round-half-up, right shift and saturation to an activation
// Ports:
//   sum : W-bit two's-complement biased accumulator
//   q   : BW_O-bit activation, always in 0 .. 2^(BW_O-1)-1
module relu_quant #(
    parameter int W     = 19,
    parameter int BW_O  = 8,
    parameter int SHIFT = 4
) (
    input  logic [W-1:0]    sum,
    output logic [BW_O-1:0] q
);
    localparam logic [W:0] RND   = (W+1)'(2 ** (SHIFT - 1));
    localparam logic [W:0] MAX_Q = (W+1)'(2 ** (BW_O - 1) - 1);

    logic [W:0] rounded;
    logic [W:0] shifted;

    // One extra bit of headroom so the rounding add of a non-negative sum cannot wrap.
    always_comb begin
        rounded = {1'b0, sum} + RND;
        shifted = rounded >> SHIFT;
        if (sum[W-1]) begin
            q = '0;
        end else if (shifted > MAX_Q) begin
            q = BW_O'(MAX_Q);
        end else begin
            q = shifted[BW_O-1:0];
        end
    end
endmodule

// File: rtl/bias_relu_quant.sv
// rtl/bias_relu_quant.sv - per-filter bias add, ReLU and 8-bit quantization of the conv accumulator stream
// Ports:
//   clk_i, rst_i                        : clock, synchronous active-high reset
//   data_i/valid_i/last_i/ready_o       : accumulator input stream (filter-major, last on final beat)
//   data_o/valid_o/last_o/ready_i       : activation output stream
//   bias_wr_en_i/addr_i/data_i          : bias register write port
//   err_o                               : sticky framing error, cleared only by reset
module bias_relu_quant
    import wrd_pkg::*;
#(
    parameter int NUM_FILTERS = 8,
    parameter int FRAME_LEN   = 50,
    parameter int BW_I        = ADD_OUT_BW,
    parameter int BW_O        = BW,
    parameter int SHIFT       = 4,
    localparam int AW         = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [BW_I-1:0] data_i,
    input  logic            valid_i,
    input  logic            last_i,
    output logic            ready_o,
    output logic [BW_O-1:0] data_o,
    output logic            valid_o,
    output logic            last_o,
    input  logic            ready_i,
    input  logic            bias_wr_en_i,
    input  logic [AW-1:0]   bias_wr_addr_i,
    input  logic [BW_I-1:0] bias_wr_data_i,
    output logic            err_o
);
    localparam int EW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [EW-1:0] ELEM_LAST = EW'(FRAME_LEN - 1);
    localparam logic [AW-1:0] FILT_LAST = AW'(NUM_FILTERS - 1);

    logic [BW_I-1:0] bias [NUM_FILTERS];
    logic [BW_I-1:0] bias_rd;
    logic [EW-1:0]   elem_cnt;
    logic [AW-1:0]   filt_cnt;
    logic            wr_in_range;
    logic            accept;
    logic            at_end;

    logic            v1;
    logic [BW_I:0]   sum1;
    logic            last1;
    logic            v2;
    logic            en1;
    logic            en2;
    logic [BW_O-1:0] q;

    assign en2     = !v2 || ready_i;
    assign en1     = !v1 || en2;
    assign ready_o = en1;
    assign valid_o = v2;
    assign accept  = valid_i && en1;
    assign at_end  = (elem_cnt == ELEM_LAST) && (filt_cnt == FILT_LAST);
    assign bias_rd = bias[filt_cnt];
    assign wr_in_range = ({1'b0, bias_wr_addr_i} < (AW+1)'(NUM_FILTERS));

    // A beat accepted alongside a write still reads the pre-edge value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                bias[i] <= '0;
            end
        end else if (bias_wr_en_i && wr_in_range) begin
            bias[bias_wr_addr_i] <= bias_wr_data_i;
        end
    end

    // Position tracking: last_i or the final position both restart the group;
    // any disagreement between the two marks a framing error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            elem_cnt <= '0;
            filt_cnt <= '0;
            err_o    <= 1'b0;
        end else if (accept) begin
            if (last_i || at_end) begin
                elem_cnt <= '0;
                filt_cnt <= '0;
                if (last_i != at_end) begin
                    err_o <= 1'b1;
                end
            end else if (elem_cnt == ELEM_LAST) begin
                elem_cnt <= '0;
                filt_cnt <= filt_cnt + 1'b1;
            end else begin
                elem_cnt <= elem_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1    <= 1'b0;
            sum1  <= '0;
            last1 <= 1'b0;
        end else if (en1) begin
            v1 <= valid_i;
            if (valid_i) begin
                sum1  <= {data_i[BW_I-1], data_i} + {bias_rd[BW_I-1], bias_rd};
                last1 <= last_i;
            end
        end
    end

    relu_quant #(
        .W     (BW_I + 1),
        .BW_O  (BW_O),
        .SHIFT (SHIFT)
    ) u_relu_quant (
        .sum (sum1),
        .q   (q)
    );

    // Output registers only load with a real beat, so they hold steady under backpressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v2     <= 1'b0;
            data_o <= '0;
            last_o <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                data_o <= q;
                last_o <= last1;
            end
        end
    end
endmodule

// File: tb/tb_bias_relu_quant.sv
// tb/tb_bias_relu_quant.sv - directed self-checking bench for bias_relu_quant
module tb_bias_relu_quant;
    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [17:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        last_i = 1'b0;
    logic        ready_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        last_o;
    logic        ready_i = 1'b0;
    logic        bias_wr_en_i = 1'b0;
    logic [2:0]  bias_wr_addr_i = '0;
    logic [17:0] bias_wr_data_i = '0;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] out_d[$];
    logic       out_l[$];
    logic       acc;
    logic       rdy_s;
    logic       vo_s;
    logic [7:0] do_s;

    always #5 clk = ~clk;

    bias_relu_quant #(
        .NUM_FILTERS (8),
        .FRAME_LEN   (50),
        .BW_I        (18),
        .BW_O        (8),
        .SHIFT       (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .last_i         (last_i),
        .ready_o        (ready_o),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .last_o         (last_o),
        .ready_i        (ready_i),
        .bias_wr_en_i   (bias_wr_en_i),
        .bias_wr_addr_i (bias_wr_addr_i),
        .bias_wr_data_i (bias_wr_data_i),
        .err_o          (err_o)
    );

    // One clock: drive inputs, observe handshakes mid-cycle, finish 1 time unit past the edge.
    task automatic step(input logic v, input logic [17:0] d, input logic l, input logic r);
        valid_i = v;
        data_i  = d;
        last_i  = l;
        ready_i = r;
        @(negedge clk);
        rdy_s = ready_o;
        vo_s  = valid_o;
        do_s  = data_o;
        acc   = v && ready_o;
        if (valid_o && r) begin
            out_d.push_back(data_o);
            out_l.push_back(last_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 18'd0, 1'b0, 1'b1);
    endtask

    task automatic wr_bias(input logic [2:0] a, input logic [17:0] d);
        bias_wr_en_i   = 1'b1;
        bias_wr_addr_i = a;
        bias_wr_data_i = d;
        step(1'b0, 18'd0, 1'b0, 1'b1);
        bias_wr_en_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bias_wr_en_i = 1'b0;
        step(1'b0, 18'd0, 1'b0, 1'b0);
        step(1'b0, 18'd0, 1'b0, 1'b0);
        rst_i = 1'b0;
        out_d.delete();
        out_l.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o: got %b want 0", valid_o); end
        n_checks++; if (data_o !== 8'd0) begin n_fail++; $display("FAIL reset_data_o: got %0d want 0", data_o); end
        n_checks++; if (last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last_o: got %b want 0", last_o); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err_o: got %b want 0", err_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_o: got %b want 1", ready_o); end
    endtask

    task automatic test_basic();
        do_reset();
        step(1'b1, 18'd100, 1'b0, 1'b1);
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: valid_o got %b want 0", valid_o); end
        step(1'b0, 18'd0, 1'b0, 1'b1);
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_latency2: valid_o got %b want 1", valid_o); end
        n_checks++; if (data_o !== 8'd6) begin n_fail++; $display("FAIL basic_data_100: got %0d want 6", data_o); end
        step(1'b0, 18'd0, 1'b0, 1'b1);
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse: valid_o got %b want 0", valid_o); end
        step(1'b1, 18'(-500), 1'b0, 1'b1);
        step(1'b1, 18'd131071, 1'b0, 1'b1);
        idle(4);
        n_checks++; if (out_d.size() !== 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", out_d.size()); end
        n_checks++; if (out_d[0] !== 8'd6) begin n_fail++; $display("FAIL basic_q0: got %0d want 6", out_d[0]); end
        n_checks++; if (out_d[1] !== 8'd0) begin n_fail++; $display("FAIL basic_relu_neg: got %0d want 0", out_d[1]); end
        n_checks++; if (out_d[2] !== 8'd127) begin n_fail++; $display("FAIL basic_saturate: got %0d want 127", out_d[2]); end
    endtask

    task automatic test_full_group();
        int bad_d;
        int bad_l;
        logic [7:0] exp_d;
        bad_d = 0;
        bad_l = 0;
        do_reset();
        wr_bias(3'd1, 18'(-1000));
        for (int i = 0; i < 400; i++) step(1'b1, 18'd1000, (i == 399), 1'b1);
        idle(4);
        n_checks++; if (out_d.size() !== 400) begin n_fail++; $display("FAIL group_count: got %0d want 400", out_d.size()); end
        for (int i = 0; i < out_d.size(); i++) begin
            exp_d = (i >= 50 && i < 100) ? 8'd0 : 8'd63;
            if (out_d[i] !== exp_d) begin
                bad_d++;
                $display("FAIL group_data[%0d]: got %0d want %0d", i, out_d[i], exp_d);
            end
            if (out_l[i] !== (i == 399)) bad_l++;
        end
        n_checks++; if (bad_d !== 0) begin n_fail++; $display("FAIL group_data_total: got %0d bad beats want 0", bad_d); end
        n_checks++; if (bad_l !== 0) begin n_fail++; $display("FAIL group_last_placement: got %0d wrong last flags want 0", bad_l); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL group_err: got %b want 0", err_o); end
    endtask

    task automatic test_bias_same_cycle();
        do_reset();
        bias_wr_en_i   = 1'b1;
        bias_wr_addr_i = 3'd0;
        bias_wr_data_i = 18'd16;
        step(1'b1, 18'd100, 1'b0, 1'b1);
        bias_wr_en_i = 1'b0;
        step(1'b1, 18'd100, 1'b0, 1'b1);
        idle(4);
        n_checks++; if (out_d[0] !== 8'd6) begin n_fail++; $display("FAIL bias_old_value: got %0d want 6", out_d[0]); end
        n_checks++; if (out_d[1] !== 8'd7) begin n_fail++; $display("FAIL bias_new_value: got %0d want 7", out_d[1]); end
    endtask

    task automatic test_back_to_back_stall();
        int idx;
        int cyc;
        int acc_w1;
        int acc_w2;
        int low_seen;
        int unstable;
        int bad;
        logic r;
        logic held_v;
        logic [7:0] held;
        idx = 0; cyc = 0; acc_w1 = 0; acc_w2 = 0; low_seen = 0; unstable = 0; bad = 0;
        held_v = 1'b0; held = '0;
        do_reset();
        while (idx < 20 && cyc < 200) begin
            r = !((cyc < 5) || (cyc >= 10 && cyc < 15));
            step(1'b1, 18'(idx * 48 + 5), 1'b0, r);
            if (!r && vo_s) begin
                if (held_v && do_s !== held) unstable++;
                held   = do_s;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (!r && !rdy_s) low_seen++;
            if (acc) begin
                if (cyc < 5) acc_w1++;
                else if (cyc >= 10 && cyc < 15) acc_w2++;
                idx++;
            end
            cyc++;
        end
        idle(4);
        n_checks++; if (idx !== 20) begin n_fail++; $display("FAIL stall_accepted: got %0d want 20", idx); end
        n_checks++; if (acc_w1 !== 2) begin n_fail++; $display("FAIL stall_fill_depth: got %0d want 2", acc_w1); end
        n_checks++; if (acc_w2 !== 0) begin n_fail++; $display("FAIL stall_full_accepts: got %0d want 0", acc_w2); end
        n_checks++; if (low_seen !== 8) begin n_fail++; $display("FAIL stall_ready_low_cycles: got %0d want 8", low_seen); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL stall_data_stable: got %0d changes want 0", unstable); end
        n_checks++; if (out_d.size() !== 20) begin n_fail++; $display("FAIL stall_out_count: got %0d want 20", out_d.size()); end
        for (int i = 0; i < out_d.size(); i++) begin
            if (out_d[i] !== 8'(3 * i) || out_l[i] !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stall_sequence: got %0d wrong beats want 0", bad); end
    endtask

    task automatic test_early_last();
        int bad_l;
        bad_l = 0;
        do_reset();
        wr_bias(3'd1, 18'd1600);
        for (int i = 0; i < 62; i++) begin
            step(1'b1, (i <= 10) ? 18'(i * 16) : 18'd0, (i == 10), 1'b1);
            if (i == 9) begin
                n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL early_err_before: got %b want 0", err_o); end
            end
            if (i == 10) begin
                n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL early_err_rise: got %b want 1", err_o); end
            end
        end
        idle(4);
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL early_err_sticky: got %b want 1", err_o); end
        n_checks++; if (out_d.size() !== 62) begin n_fail++; $display("FAIL early_count: got %0d want 62", out_d.size()); end
        n_checks++; if (out_l[10] !== 1'b1) begin n_fail++; $display("FAIL early_last_o_beat10: got %b want 1", out_l[10]); end
        for (int i = 0; i < out_l.size(); i++) if (i != 10 && out_l[i] !== 1'b0) bad_l++;
        n_checks++; if (bad_l !== 0) begin n_fail++; $display("FAIL early_last_elsewhere: got %0d want 0", bad_l); end
        n_checks++; if (out_d[10] !== 8'd10) begin n_fail++; $display("FAIL early_data10: got %0d want 10", out_d[10]); end
        n_checks++; if (out_d[60] !== 8'd0) begin n_fail++; $display("FAIL early_filter0_end: got %0d want 0", out_d[60]); end
        n_checks++; if (out_d[61] !== 8'd100) begin n_fail++; $display("FAIL early_filter1_start: got %0d want 100", out_d[61]); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        wr_bias(3'd0, 18'd160);
        step(1'b1, 18'd100, 1'b0, 1'b0);
        step(1'b1, 18'd100, 1'b0, 1'b0);
        rst_i = 1'b1;
        step(1'b0, 18'd0, 1'b0, 1'b0);
        rst_i = 1'b0;
        out_d.delete();
        out_l.delete();
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_o: got %b want 0", valid_o); end
        idle(3);
        n_checks++; if (out_d.size() !== 0) begin n_fail++; $display("FAIL midrst_flushed: got %0d beats want 0", out_d.size()); end
        step(1'b1, 18'd100, 1'b0, 1'b1);
        idle(4);
        n_checks++; if (out_d.size() !== 1) begin n_fail++; $display("FAIL midrst_count: got %0d want 1", out_d.size()); end
        n_checks++; if (out_d[0] !== 8'd6) begin n_fail++; $display("FAIL midrst_bias_cleared: got %0d want 6", out_d[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_group();
        test_bias_same_cycle();
        test_back_to_back_stall();
        test_early_last();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bias_relu_quant.md
# bias_relu_quant

Post-processing stage directly downstream of the 1D convolution engine. Consumes the convolution's signed accumulator stream (filter-major: FRAME_LEN outputs for filter 0, then filter 1, … through NUM_FILTERS-1, with `last` on the final beat) and adds a per-filter bias. It then applies ReLU and rounds, shifts and saturates each result to an 8-bit activation for the next layer. Fully pipelined, one beat per cycle, valid/ready/last handshake on both sides.

## Interface
- `NUM_FILTERS`, 8, filters per frame group; bias register count.
- `FRAME_LEN`, 50, beats per filter.
- `BW_I`, 18, input accumulator width (signed).
- `BW_O`, 8, output activation width (signed, always ≥ 0).
- `SHIFT`, 4, quantization right-shift (≥ 1).
- `clk_i` in 1: clock; all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `data_i` in BW_I: signed accumulator.
- `valid_i` in 1: input beat valid.
- `last_i` in 1: final beat of frame group.
- `ready_o` out 1: stage accepts a beat this cycle.
- `data_o` out BW_O: quantized activation.
- `valid_o` out 1: output beat valid.
- `last_o` out 1: `last_i` of this beat, delayed.
- `ready_i` in 1: downstream accepts.
- `bias_wr_en_i` in 1: bias write strobe.
- `bias_wr_addr_i` in clog2(NUM_FILTERS): filter index.
- `bias_wr_data_i` in BW_I: signed bias.
- `err_o` out 1: sticky framing error.

## Operation
- Beat accepted when `valid_i && ready_o`. Transfer out when `valid_o && ready_i`.
- Position counters `elem_cnt` (0..FRAME_LEN-1) and `filt_cnt` (0..NUM_FILTERS-1) advance on each accepted beat. `elem_cnt` wraps and increments `filt_cnt`.
- Stage 1, on accept: `sum = data_i + bias[filt_cnt]`, sign-extended to BW_I+1 bits; register `sum` and `last_i`.
- Stage 2: ReLU (`sum < 0` → 0), then `q = (sum + 2^(SHIFT-1)) >> SHIFT`, then saturate to 2^(BW_O-1)-1 (127). Register `q` and `last`.
- Accepted beat with `last_i`: both counters reset to 0. If position ≠ (NUM_FILTERS-1, FRAME_LEN-1), set `err_o`.
- Accepted beat at final position without `last_i`: counters wrap to 0 and `err_o` is set.
- `err_o` is cleared only by reset. Data always passes through unchanged by errors.
- Bias write: register updated at clock edge. A beat accepted in the same cycle as the write uses the old value; later beats use the new value. Out-of-range address is ignored.

## Timing
- Reset values: `valid_o`=0, `data_o`=0, `last_o`=0, `err_o`=0, counters 0, all biases 0, internal valids 0.
- Latency: 2 cycles from accept to `valid_o`, with `ready_i` held high. Throughput 1 beat/cycle.
- Stall logic: `en2 = !v2 || ready_i`; `en1 = !v1 || en2`; `ready_o = en1`. Combinational path from `ready_i` to `ready_o` is permitted.
- With `ready_i` low, at most 2 beats are held. `data_o`/`last_o` remain stable while `valid_o && !ready_i`.
- Simultaneous accept and drain: both happen in the same cycle, with no bubble.
- Reset asserted mid-stream: in-flight beats are discarded, counters zeroed, biases zeroed. No output beat is emitted in the cycle after reset.
- `err_o` rises in the cycle after the offending accept.

## Structure
- Shared package `wrd_pkg`: `BW=8`, `MUL_OUT_BW=16`, `ADD_OUT_BW=18` constants, shared with the convolution stage. Defaults for `BW_I`/`BW_O` derive from these.
- Sub-module `relu_quant`: combinational ReLU + round + shift + saturate, parameterized by width and SHIFT. Instantiated in stage 2.
- Top holds the bias register file, position counters, error flag and two-stage valid/ready pipeline.

## Test plan
- Biases 0, SHIFT=4, `data_i`=100 single beat → `data_o`=6 two cycles later, `valid_o` pulses once.
- `data_i`=-500, bias 0 → `data_o`=0. `data_i`=131071 → `data_o`=127 (saturated).
- `bias[1]`=-1000, full group of 400 beats, all `data_i`=1000 → beats 0–49 give 63 (1000+8>>4); beats 50–99 give 0; `last_o` only on beat 399; `err_o`=0.
- Write `bias[0]`=16 in the same cycle beat 0 is accepted → beat 0 uses bias 0, beat 1 uses bias 16 (100 → 6, then 116 → 7).
- Random `ready_i` low for 5 cycles mid-stream → `ready_o` drops once 2 beats are held. Output sequence matches the reference model exactly: no drop, duplicate or reorder.
- `last_i` on beat 10 of a group → `err_o`=1 next cycle and stays 1. Next beat is treated as filter 0, element 0. `last_o` accompanies output beat 10.
